// File: rtl/pong_pkg.sv
// Shared colour codes, direction encoding and default geometry for the pong graphics stage.
package pong_pkg;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK  = 3'b000;
  localparam rgb_t RGB_BLUE   = 3'b001;
  localparam rgb_t RGB_GREEN  = 3'b010;
  localparam rgb_t RGB_RED    = 3'b100;
  localparam rgb_t RGB_YELLOW = 3'b110;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

  localparam int DEF_H_VIS     = 640;
  localparam int DEF_V_VIS     = 480;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_COLOR_W   = 1;
  localparam int DEF_WALL_X_L  = 32;
  localparam int DEF_WALL_X_R  = 35;
  localparam int DEF_BAR_X_L   = 600;
  localparam int DEF_BAR_X_R   = 603;
  localparam int DEF_BAR_H     = 72;
  localparam int DEF_BAR_V     = 4;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_BALL_V    = 2;

endpackage

// File: rtl/pong_ball_rom.sv
// 8x8 circle bitmap for the round ball; one 8-bit row per 3-bit row address.
// Only built when PONG_ROUND_BALL_EN is defined.
`ifdef PONG_ROUND_BALL_EN
module pong_ball_rom (
  input  logic [2:0] addr,
  output logic [7:0] row
);

  always_comb begin
    row = 8'h00;
    case (addr)
      3'd0: row = 8'b0011_1100;
      3'd1: row = 8'b0111_1110;
      3'd2: row = 8'b1111_1111;
      3'd3: row = 8'b1111_1111;
      3'd4: row = 8'b1111_1111;
      3'd5: row = 8'b1111_1111;
      3'd6: row = 8'b0111_1110;
      3'd7: row = 8'b0011_1100;
      default: row = 8'h00;
    endcase
  end

endmodule
`endif

// File: rtl/pong_graph_anim.sv
// Animated pong graphics: paddle/ball state updated once per frame, registered RGB per pixel tick.
// Define PONG_ROUND_BALL_EN to mask the ball with the 8x8 circle bitmap (BALL_SIZE must be 8).
module pong_graph_anim
  import pong_pkg::*;
#(
  parameter int H_VIS     = DEF_H_VIS,
  parameter int V_VIS     = DEF_V_VIS,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int WALL_X_L  = DEF_WALL_X_L,
  parameter int WALL_X_R  = DEF_WALL_X_R,
  parameter int BAR_X_L   = DEF_BAR_X_L,
  parameter int BAR_X_R   = DEF_BAR_X_R,
  parameter int BAR_H     = DEF_BAR_H,
  parameter int BAR_V     = DEF_BAR_V,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int BALL_V    = DEF_BALL_V
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_tick,
  input  logic                   video_on,
  input  logic [COORD_W-1:0]     pix_x,
  input  logic [COORD_W-1:0]     pix_y,
  input  logic [1:0]             btn,
  output logic [3*COLOR_W-1:0]   graph_rgb,
  output logic                   hit,
  output logic                   miss
);

  localparam int CW = COORD_W;

  localparam logic [CW-1:0] BAR_Y_RST    = CW'((V_VIS - BAR_H) / 2);
  localparam logic [CW-1:0] BALL_X_RST   = CW'(H_VIS / 2);
  localparam logic [CW-1:0] BALL_Y_RST   = CW'(V_VIS / 2);
  localparam logic [CW-1:0] K_VIS_Y      = CW'(V_VIS);
  localparam logic [CW-1:0] K_BAR_V      = CW'(BAR_V);
  localparam logic [CW-1:0] K_BAR_H1     = CW'(BAR_H - 1);
  localparam logic [CW-1:0] K_BAR_DN_LIM = CW'(V_VIS - 1 - BAR_V);
  localparam logic [CW-1:0] K_BALL_S1    = CW'(BALL_SIZE - 1);
  localparam logic [CW-1:0] K_BALL_V     = CW'(BALL_V);
  localparam logic [CW-1:0] K_BALL_DN    = CW'(V_VIS - 1 - BALL_V);
  localparam logic [CW-1:0] K_MISS_X     = CW'(H_VIS - 1);
  localparam logic [CW-1:0] K_WALL_L     = CW'(WALL_X_L);
  localparam logic [CW-1:0] K_WALL_R     = CW'(WALL_X_R);
  localparam logic [CW-1:0] K_BAR_L      = CW'(BAR_X_L);
  localparam logic [CW-1:0] K_BAR_R      = CW'(BAR_X_R);

  logic [CW-1:0] bar_y_q, bar_y_d;
  logic [CW-1:0] ball_x_q, ball_x_d;
  logic [CW-1:0] ball_y_q, ball_y_d;
  dir_e          dir_x_q, dir_x_d;
  dir_e          dir_y_q, dir_y_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  logic          refr_tick;
  logic [CW-1:0] bar_bot, ball_right, ball_bot;
  logic          hit_cond, miss_cond;
  logic          wall_on, bar_on, sq_ball_on, ball_on;
  rgb_t          pix_rgb;

  assign refr_tick  = p_tick && (pix_x == '0) && (pix_y == K_VIS_Y);
  assign bar_bot    = bar_y_q + K_BAR_H1;
  assign ball_right = ball_x_q + K_BALL_S1;
  assign ball_bot   = ball_y_q + K_BALL_S1;

  // x + BALL_SIZE > H_VIS-1 is the same test as right edge >= H_VIS-1
  assign miss_cond = (ball_right >= K_MISS_X);
  assign hit_cond  = !miss_cond && (dir_x_q == DIR_INC) &&
                     (ball_right >= K_BAR_L) && (ball_right <= K_BAR_R) &&
                     (ball_bot >= bar_y_q) && (ball_y_q <= bar_bot);

  assign hit  = refr_tick && hit_cond;
  assign miss = refr_tick && miss_cond;

  always_comb begin
    bar_y_d  = bar_y_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    if (refr_tick) begin
      if (btn == 2'b10 && bar_y_q > K_BAR_V) begin
        bar_y_d = bar_y_q - K_BAR_V;
      end else if (btn == 2'b01 && bar_bot < K_BAR_DN_LIM) begin
        bar_y_d = bar_y_q + K_BAR_V;
      end

      if (miss_cond) begin
        ball_x_d = BALL_X_RST;
        ball_y_d = BALL_Y_RST;
        dir_x_d  = DIR_DEC;
        dir_y_d  = DIR_INC;
      end else begin
        if (hit_cond) begin
          dir_x_d = DIR_DEC;
        end else if (ball_x_q <= K_WALL_R) begin
          dir_x_d = DIR_INC;
        end
        if (ball_y_q <= K_BALL_V) begin
          dir_y_d = DIR_INC;
        end else if (ball_bot >= K_BALL_DN) begin
          dir_y_d = DIR_DEC;
        end
        // Move with the freshly chosen directions
        ball_x_d = (dir_x_d == DIR_INC) ? ball_x_q + K_BALL_V : ball_x_q - K_BALL_V;
        ball_y_d = (dir_y_d == DIR_INC) ? ball_y_q + K_BALL_V : ball_y_q - K_BALL_V;
      end
    end
  end

  assign wall_on    = (pix_x >= K_WALL_L) && (pix_x <= K_WALL_R);
  assign bar_on     = (pix_x >= K_BAR_L) && (pix_x <= K_BAR_R) &&
                      (pix_y >= bar_y_q) && (pix_y <= bar_bot);
  assign sq_ball_on = (pix_x >= ball_x_q) && (pix_x <= ball_right) &&
                      (pix_y >= ball_y_q) && (pix_y <= ball_bot);

`ifdef PONG_ROUND_BALL_EN
  logic [2:0] rom_addr, rom_col;
  logic [7:0] rom_row;

  // Offsets inside an 8-pixel ball only need the low three bits
  assign rom_addr = pix_y[2:0] - ball_y_q[2:0];
  assign rom_col  = pix_x[2:0] - ball_x_q[2:0];

  pong_ball_rom u_ball_rom (
    .addr (rom_addr),
    .row  (rom_row)
  );

  assign ball_on = sq_ball_on && rom_row[rom_col];
`else
  assign ball_on = sq_ball_on;
`endif

  always_comb begin
    pix_rgb = RGB_YELLOW;
    if (!video_on) begin
      pix_rgb = RGB_BLACK;
    end else if (wall_on) begin
      pix_rgb = RGB_BLUE;
    end else if (bar_on) begin
      pix_rgb = RGB_GREEN;
    end else if (ball_on) begin
      pix_rgb = RGB_RED;
    end
    rgb_d = rgb_q;
    if (p_tick) begin
      rgb_d = {{COLOR_W{pix_rgb[2]}}, {COLOR_W{pix_rgb[1]}}, {COLOR_W{pix_rgb[0]}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_y_q  <= BAR_Y_RST;
      ball_x_q <= BALL_X_RST;
      ball_y_q <= BALL_Y_RST;
      dir_x_q  <= DIR_INC;
      dir_y_q  <= DIR_INC;
      rgb_q    <= '0;
    end else begin
      bar_y_q  <= bar_y_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      rgb_q    <= rgb_d;
    end
  end

  assign graph_rgb = rgb_q;

endmodule

// File: tb/tb_pong_graph_anim.sv
// Scoreboard bench for pong_graph_anim: a behavioural game model predicts pixel colours and
// hit/miss pulses; the ball shape follows PONG_ROUND_BALL_EN like the design.
module tb_pong_graph_anim;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam logic [7:0] CIRCLE [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic [9:0] pix_x, pix_y;
  logic [1:0] btn;
  logic [2:0] graph_rgb;
  logic       hit, miss;

  pong_graph_anim dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .btn       (btn),
    .graph_rgb (graph_rgb),
    .hit       (hit),
    .miss      (miss)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural game state
  int m_bar, m_bx, m_by;
  bit m_dx, m_dy;
  int hits_seen, misses_seen;

  logic [2:0] rgb_q[$];
  string      tag_q[$];
  logic [1:0] pulse_q[$];
  bit         pt_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_rgb(input int x, input int y, input bit von);
    if (!von) return 3'b000;
    if (x >= 32 && x <= 35) return 3'b001;
    if (x >= 600 && x <= 603 && y >= m_bar && y <= m_bar + 71) return 3'b010;
    if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) begin
`ifdef PONG_ROUND_BALL_EN
      logic [7:0] r;
      r = CIRCLE[y - m_by];
      return r[x - m_bx] ? 3'b100 : 3'b110;
`else
      return 3'b100;
`endif
    end
    return 3'b110;
  endfunction

  task automatic model_reset();
    m_bar = 204; m_bx = 320; m_by = 240; m_dx = 1'b1; m_dy = 1'b1;
  endtask

  task automatic model_frame(output bit eh, output bit em);
    em = (m_bx + 8 > H_VIS - 1);
    eh = !em && m_dx && (m_bx + 7 >= 600) && (m_bx + 7 <= 603) &&
         (m_by + 7 >= m_bar) && (m_by <= m_bar + 71);
    if (btn == 2'b10 && m_bar > 4) m_bar -= 4;
    else if (btn == 2'b01 && m_bar + 71 < V_VIS - 1 - 4) m_bar += 4;
    if (em) begin
      m_bx = H_VIS / 2; m_by = V_VIS / 2; m_dx = 1'b0; m_dy = 1'b1;
    end else begin
      if (eh) m_dx = 1'b0;
      else if (m_bx <= 35) m_dx = 1'b1;
      if (m_by <= 2) m_dy = 1'b1;
      else if (m_by + 7 >= V_VIS - 1 - 2) m_dy = 1'b0;
      m_bx = m_dx ? m_bx + 2 : m_bx - 2;
      m_by = m_dy ? m_by + 2 : m_by - 2;
    end
  endtask

  // Monitor: compare registered colour one p_tick later, pulses during refr_tick
  always @(posedge clk) pt_seen <= (p_tick === 1'b1) && (reset === 1'b1);

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_val("rst_rgb", {29'd0, graph_rgb}, 32'd0);
      check_val("rst_pulse", {30'd0, hit, miss}, 32'd0);
    end else begin
      if (pt_seen) begin
        if (rgb_q.size() == 0) check_val("rgb_sb_underflow", rgb_q.size(), 32'd1);
        else check_val(tag_q.pop_front(), {29'd0, graph_rgb}, {29'd0, rgb_q.pop_front()});
      end
      if (p_tick === 1'b1 && pix_x == 10'd0 && pix_y == 10'(V_VIS)) begin
        if (pulse_q.size() == 0) check_val("pulse_sb_underflow", pulse_q.size(), 32'd1);
        else check_val("hit_miss", {30'd0, hit, miss}, {30'd0, pulse_q.pop_front()});
      end else begin
        check_val("pulse_idle", {30'd0, hit, miss}, 32'd0);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    p_tick = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input bit von = 1'b1);
    @(posedge clk); #1;
    p_tick = 1'b1; video_on = von; pix_x = 10'(x); pix_y = 10'(y);
    rgb_q.push_back(model_rgb(x, y, von));
    tag_q.push_back($sformatf("rgb(%0d,%0d,v%0d)", x, y, von));
  endtask

  task automatic frame();
    bit eh, em;
    @(posedge clk); #1;
    p_tick = 1'b1; video_on = 1'b0; pix_x = 10'd0; pix_y = 10'(V_VIS);
    rgb_q.push_back(3'b000);
    tag_q.push_back("rgb_refr");
    model_frame(eh, em);
    pulse_q.push_back({eh, em});
    if (eh) hits_seen++;
    if (em) misses_seen++;
  endtask

  task automatic probe_set();
    probe(33, 100);
    probe(601, m_bar);
    probe(601, m_bar - 1);
    probe(601, m_bar + 71);
    probe(601, m_bar + 72);
    probe(m_bx, m_by);
    probe(m_bx + 7, m_by + 7);
    probe(m_bx + 3, m_by);
    probe(m_bx - 1, m_by + 3);
    probe(m_bx + 8, m_by + 3);
    probe(m_bx + 3, m_by + 3, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      p_tick = 1'b1; video_on = 1'b1; pix_x = 10'd33; pix_y = 10'd100;
    end
    @(posedge clk); #1;
    p_tick = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0;
    pix_x = '0; pix_y = '0; btn = 2'b00;
    hits_seen = 0; misses_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    repeat (5) begin
      @(posedge clk); #1;
      p_tick = 1'b1; video_on = 1'b1; pix_x = 10'd33; pix_y = 10'd100;
    end
    @(posedge clk); #1;
    p_tick = 1'b0;
    reset = 1'b1;
    probe_set();

    btn = 2'b10;
    repeat (60) begin frame(); probe_set(); end
    btn = 2'b11;
    repeat (5) begin frame(); probe_set(); end
    btn = 2'b01;
    repeat (10) begin frame(); probe_set(); end

    btn = 2'b00;
    repeat (3) begin frame(); probe_set(); end
    do_reset();
    probe_set();

    // Paddle tracks the ball until a bounce off the paddle
    k = 0;
    while (hits_seen == 0 && k < 900) begin
      if (m_bar + 36 < m_by + 4) btn = 2'b01;
      else if (m_bar + 36 > m_by + 4) btn = 2'b10;
      else btn = 2'b00;
      frame(); probe_set();
      k++;
    end
    check_val("hit_reached", hits_seen, 32'd1);
    btn = 2'b00;
    repeat (3) begin frame(); probe_set(); end

    // Paddle dodges the ball until it is missed
    k = 0;
    while (misses_seen == 0 && k < 1500) begin
      btn = (m_by + 4 < m_bar + 36) ? 2'b01 : 2'b10;
      frame(); probe_set();
      k++;
    end
    check_val("miss_reached", misses_seen, 32'd1);
    btn = 2'b00;
    repeat (3) begin frame(); probe_set(); end

    idle();
    idle();
    idle();
    check_val("sb_drain", rgb_q.size() + pulse_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
